// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type, and arbiter FSM encoding.
// Pure declarations; no timing or flow-control behaviour lives here.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    DGNT,
    IGNT0,
    IGNT1
  } arb_state_t;

  localparam int IMAX_DEFAULT = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side opposite 'last'.
// Purely combinational, zero latency, no backpressure of its own.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       vld
);

  always_comb begin
    vld = |req;
    case (req)
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Single RAM port shared by the coherence data channel and two instruction ports; data first, starving fetches override.
// Request in cycle N drives RAM in N+1; waits stay high until ACCESS, with one IDLE bubble between grants.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32,
  parameter int IMAX   = IMAX_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       dREN,
  input  logic                       dWEN,
  input  logic [WORD_W-1:0]          daddr,
  input  logic [WORD_W-1:0]          dstore,
  input  logic                       dlock,
  output logic [WORD_W-1:0]          dload,
  output logic                       dwait,
  input  logic [CPUS-1:0]            iREN,
  input  logic [CPUS-1:0][WORD_W-1:0] iaddr,
  output logic [WORD_W-1:0]          iload,
  output logic [CPUS-1:0]            iwait,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [WORD_W-1:0]          ramaddr,
  output logic [WORD_W-1:0]          ramstore,
  input  logic [WORD_W-1:0]          ramload,
  input  ramstate_t                  ramstate,
  output logic                       ram_err
);

  localparam int SW = $clog2(IMAX + 1);
  localparam logic [SW-1:0] IMAX_C = SW'(IMAX);

  arb_state_t      state_q, state_d;
  logic            last_i_q, last_i_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            ram_err_q, ram_err_d;

  logic            pick_idx;
  logic            pick_vld;
  logic            d_req;
  logic            acc;
  arb_state_t      igrant;

  rr_pick2 u_pick (
    .req  (iREN[1:0]),
    .last (last_i_q),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_comb begin
    d_req     = dREN | dWEN;
    acc       = (ramstate == ACCESS);
    igrant    = pick_idx ? IGNT1 : IGNT0;

    state_d   = state_q;
    last_i_d  = last_i_q;
    starve_d  = starve_q;
    ram_err_d = ram_err_q;

    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    dload     = '0;
    dwait     = 1'b1;
    iload     = '0;
    iwait     = '1;

    case (state_q)
      IDLE: begin
        if (dlock) begin
          if (d_req) state_d = DGNT;
        end else if ((starve_q >= IMAX_C) && pick_vld) begin
          state_d = igrant;
        end else if (d_req) begin
          state_d = DGNT;
        end else if (pick_vld) begin
          state_d = igrant;
        end
      end

      // A dropped request deasserts the enables and releases no wait.
      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~(d_req & acc);
        if (!d_req || acc) state_d = IDLE;
      end

      IGNT0: begin
        ramREN   = iREN[0];
        ramaddr  = iaddr[0];
        iload    = ramload;
        iwait[0] = ~(iREN[0] & acc);
        if (!iREN[0]) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d  = IDLE;
          last_i_d = 1'b0;
        end
      end

      IGNT1: begin
        ramREN   = iREN[1];
        ramaddr  = iaddr[1];
        iload    = ramload;
        iwait[1] = ~(iREN[1] & acc);
        if (!iREN[1]) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d  = IDLE;
          last_i_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (ramstate == ERROR)) ram_err_d = 1'b1;

    // Starvation age counts every waiting cycle outside an instruction grant.
    if ((state_q == IDLE) && ((state_d == IGNT0) || (state_d == IGNT1))) begin
      starve_d = '0;
    end else if ((|iREN) && (state_q != IGNT0) && (state_q != IGNT1) &&
                 (starve_q != IMAX_C)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      last_i_q  <= 1'b1;
      starve_q  <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_i_q  <= last_i_d;
      starve_q  <= starve_d;
      ram_err_q <= ram_err_d;
    end
  end

  assign ram_err = ram_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: per-cycle vector table from reset, then scoreboarded grant-order sequences.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              dREN = 1'b0, dWEN = 1'b0, dlock = 1'b0;
  logic [31:0]       daddr = '0, dstore = '0;
  logic [31:0]       dload;
  logic              dwait;
  logic [1:0]        iREN = '0;
  logic [1:0][31:0]  iaddr;
  logic [31:0]       iload;
  logic [1:0]        iwait;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore;
  logic [31:0]       ramload = '0;
  ramstate_t         ramstate = FREE;
  logic              ram_err;

  int n_vec = 0;
  int n_bad = 0;
  int rcnt  = 0;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        dr, dw;
    logic [31:0] da, ds;
    logic [1:0]  ir;
    ramstate_t   rs;
    logic [31:0] rl;
    logic        e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    logic        e_dwait;
    logic [1:0]  e_iwait;
    logic [31:0] e_dload, e_iload;
    logic        e_err;
  } vec_t;

  vec_t vecs[22];

  always #5 CLK = ~CLK;

  ram_arbiter #(.CPUS(2), .WORD_W(32), .IMAX(8)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dlock(dlock),
    .dload(dload), .dwait(dwait),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
    input logic [1:0] ir, input ramstate_t rs, input logic [31:0] rl,
    input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] es,
    input logic edw, input logic [1:0] eiw, input logic [31:0] edl,
    input logic [31:0] eil, input logic eerr);
    vec_t v;
    v.dr = dr; v.dw = dw; v.da = da; v.ds = ds; v.ir = ir; v.rs = rs; v.rl = rl;
    v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es; v.e_dwait = edw;
    v.e_iwait = eiw; v.e_dload = edl; v.e_iload = eil; v.e_err = eerr;
    return v;
  endfunction

  function automatic vec_t idle_v(input logic dr, input logic dw, input logic [31:0] da,
                                  input logic [31:0] ds, input logic [1:0] ir,
                                  input ramstate_t rs);
    return mkv(dr, dw, da, ds, ir, rs, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 2'b11,
               32'h0, 32'h0, 1'b0);
  endfunction

  task automatic reset_dut();
    @(negedge CLK);
    RST = 1'b1;
    dREN = 1'b0; dWEN = 1'b0; dlock = 1'b0; iREN = 2'b00;
    daddr = '0; dstore = '0; ramstate = FREE; ramload = '0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // RAM model: answers ACCESS on the lat-th consecutive enabled cycle.
  task automatic ram_model(input int lat);
    if (ramREN || ramWEN) begin
      ramload = ramaddr + 32'h1;
      if (rcnt == lat - 1) begin
        ramstate = ACCESS;
        rcnt = 0;
      end else begin
        ramstate = BUSY;
        rcnt++;
      end
    end else begin
      ramstate = FREE;
      rcnt = 0;
    end
  endtask

  task automatic sb_sample(input int cyc, output logic d_done, output logic [1:0] i_done);
    sb_t e;
    d_done = ~dwait;
    i_done = ~iwait;
    if (d_done || (|i_done)) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_completion", 160'(ramaddr), 160'hFFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("sb_grant_addr", 160'(ramaddr), 160'(e.addr));
        chk("sb_grant_cycle", 160'(cyc), 160'(e.cyc));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        dd;
    logic [1:0]  id;
    int          dcount;
    logic [133:0] act, exp;

    iaddr[0] = 32'h200;
    iaddr[1] = 32'h300;

    vecs[0]  = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[1]  = idle_v(1, 0, 32'h40, 32'h0, 2'b00, BUSY);
    vecs[2]  = mkv(1, 0, 32'h40, 32'h0, 2'b00, BUSY, 32'h0,
                   1, 0, 32'h40, 32'h0, 1, 2'b11, 32'h0, 32'h0, 0);
    vecs[3]  = mkv(1, 0, 32'h40, 32'h0, 2'b00, ACCESS, 32'hDEADBEEF,
                   1, 0, 32'h40, 32'h0, 0, 2'b11, 32'hDEADBEEF, 32'h0, 0);
    vecs[4]  = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[5]  = idle_v(1, 1, 32'h80, 32'h12345678, 2'b00, FREE);
    vecs[6]  = mkv(1, 1, 32'h80, 32'h12345678, 2'b00, BUSY, 32'h0,
                   0, 1, 32'h80, 32'h12345678, 1, 2'b11, 32'h0, 32'h0, 0);
    vecs[7]  = mkv(1, 1, 32'h80, 32'h12345678, 2'b00, ACCESS, 32'h5,
                   0, 1, 32'h80, 32'h12345678, 0, 2'b11, 32'h5, 32'h0, 0);
    vecs[8]  = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[9]  = idle_v(1, 0, 32'hC0, 32'h0, 2'b00, FREE);
    vecs[10] = mkv(0, 0, 32'hC0, 32'h0, 2'b00, ACCESS, 32'h0,
                   0, 0, 32'hC0, 32'h0, 1, 2'b11, 32'h0, 32'h0, 0);
    vecs[11] = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[12] = idle_v(0, 0, 32'h0, 32'h0, 2'b01, FREE);
    vecs[13] = mkv(0, 0, 32'h0, 32'h0, 2'b01, ACCESS, 32'hCAFEF00D,
                   1, 0, 32'h200, 32'h0, 1, 2'b10, 32'h0, 32'hCAFEF00D, 0);
    vecs[14] = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[15] = idle_v(0, 0, 32'h0, 32'h0, 2'b11, FREE);
    vecs[16] = mkv(0, 0, 32'h0, 32'h0, 2'b11, ACCESS, 32'h11112222,
                   1, 0, 32'h300, 32'h0, 1, 2'b01, 32'h0, 32'h11112222, 0);
    vecs[17] = idle_v(0, 0, 32'h0, 32'h0, 2'b01, FREE);
    vecs[18] = mkv(0, 0, 32'h0, 32'h0, 2'b01, ACCESS, 32'h33334444,
                   1, 0, 32'h200, 32'h0, 1, 2'b10, 32'h0, 32'h33334444, 0);
    vecs[19] = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);
    vecs[20] = idle_v(0, 0, 32'h0, 32'h0, 2'b00, ERROR);
    vecs[21] = idle_v(0, 0, 32'h0, 32'h0, 2'b00, FREE);

    reset_dut();
    for (int i = 0; i < 22; i++) begin
      @(negedge CLK);
      dREN = vecs[i].dr; dWEN = vecs[i].dw; daddr = vecs[i].da; dstore = vecs[i].ds;
      iREN = vecs[i].ir; ramstate = vecs[i].rs; ramload = vecs[i].rl; dlock = 1'b0;
      #1;
      act = {ramREN, ramWEN, ramaddr, ramstore, dwait, iwait, dload, iload, ram_err};
      exp = {vecs[i].e_ren, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_store, vecs[i].e_dwait,
             vecs[i].e_iwait, vecs[i].e_dload, vecs[i].e_iload, vecs[i].e_err};
      chk($sformatf("vec%0d", i), 160'(act), 160'(exp));
    end

    // Data vs both instruction ports, RAM always ready.
    reset_dut();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h100; iREN = 2'b11;
    sb_q.push_back('{32'h100, 1});
    sb_q.push_back('{32'h200, 3});
    sb_q.push_back('{32'h300, 5});
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) begin
      ram_model(1);
      #1;
      sb_sample(c, dd, id);
      if (dd) dREN = 1'b0;
      if (id[0]) iREN[0] = 1'b0;
      if (id[1]) iREN[1] = 1'b0;
      @(negedge CLK);
    end
    chk("conflict_drain", 160'(sb_q.size()), 160'(0));
    sb_q.delete();

    // Two-word locked burst while core 1 keeps requesting.
    reset_dut();
    @(negedge CLK);
    dREN = 1'b1; dlock = 1'b1; daddr = 32'h500; iREN = 2'b10; dcount = 0;
    sb_q.push_back('{32'h500, 1});
    sb_q.push_back('{32'h504, 3});
    sb_q.push_back('{32'h300, 5});
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) begin
      ram_model(1);
      #1;
      if (dlock) chk($sformatf("lock_iwait1_c%0d", c), 160'(iwait[1]), 160'(1));
      sb_sample(c, dd, id);
      if (dd) begin
        dcount++;
        if (dcount == 1) begin
          daddr = 32'h504;
        end else begin
          dREN = 1'b0;
          dlock = 1'b0;
        end
      end
      if (id[1]) iREN[1] = 1'b0;
      @(negedge CLK);
    end
    chk("burst_drain", 160'(sb_q.size()), 160'(0));
    sb_q.delete();

    // Starvation: data always pending, RAM needs 3 cycles per access.
    reset_dut();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h600; iREN = 2'b01;
    sb_q.push_back('{32'h600, 3});
    sb_q.push_back('{32'h604, 7});
    sb_q.push_back('{32'h200, 11});
    for (int c = 0; c < 60 && sb_q.size() != 0; c++) begin
      ram_model(3);
      #1;
      sb_sample(c, dd, id);
      if (dd) daddr = daddr + 32'h4;
      if (id[0]) begin
        iREN = 2'b00;
        dREN = 1'b0;
      end
      @(negedge CLK);
    end
    chk("starve_drain", 160'(sb_q.size()), 160'(0));
    sb_q.delete();

    // ERROR during a data grant, then reset mid-access.
    reset_dut();
    @(negedge CLK);
    dREN = 1'b1; daddr = 32'h700; ramstate = FREE;
    @(negedge CLK);
    ramstate = ERROR;
    #1;
    chk("err_ren", 160'(ramREN), 160'(1));
    chk("err_dwait", 160'(dwait), 160'(1));
    chk("err_flag_before_edge", 160'(ram_err), 160'(0));
    @(negedge CLK);
    #1;
    chk("err_still_granted", 160'(ramREN), 160'(1));
    chk("err_dwait_held", 160'(dwait), 160'(1));
    chk("err_flag_set", 160'(ram_err), 160'(1));
    @(negedge CLK);
    RST = 1'b1;
    ramstate = FREE;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rst_err_clear", 160'(ram_err), 160'(0));
    chk("rst_idle_ren", 160'(ramREN), 160'(0));
    chk("rst_idle_dwait", 160'(dwait), 160'(1));
    @(negedge CLK);
    #1;
    chk("rst_regrant_ren", 160'(ramREN), 160'(1));
    dREN = 1'b0;

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sits directly downstream of coherence_control and the two icaches, in front of the single RAM port.
- Merges three requesters onto one RAM port: the coherence controller's data channel and the instruction fetch ports of core 0 and core 1.
- Data has priority, with a starvation guard for instruction fetches. Instruction fetches between the two cores are round-robin.
- Holds the port for multi-word coherence bursts and returns RAM data and wait to whichever requester is granted.

Parameters:
- CPUS, 2, number of cores / instruction ports; the logic is written for 2.
- WORD_W, 32, data/address width.
- IMAX, 8, cycles an instruction request may wait before it overrides data priority.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- dREN  in  1  data read request from coherence control
- dWEN  in  1  data write request from coherence control
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- dlock  in  1  data burst in progress; blocks instruction grants
- dload  out  WORD_W  data read value
- dwait  out  1  data channel stall
- iREN  in  CPUS  per-core instruction read request
- iaddr  in  CPUS×WORD_W  per-core instruction address
- iload  out  WORD_W  instruction read value, broadcast to both cores
- iwait  out  CPUS  per-core instruction stall
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write value
- ramload  in  WORD_W  RAM read value
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ram_err  out  1  sticky: ERROR was seen while a grant was active

Behaviour:
- States: IDLE, DGNT, IGNT0, IGNT1. All registered. RAM outputs are driven combinationally from the current state and the granted requester's inputs.
- Reset (RST high at a posedge):
  - state=IDLE, last_i=1 (core 0 wins the first tie), starve_cnt=0, ram_err=0.
  - RST high in any state, including mid-access, forces IDLE at that edge. The aborted access is not reported as complete.
- IDLE outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=1, iwait='1, dload=iload=0.
- Arbitration, evaluated in IDLE only; the winner's grant state is entered at the next edge:
  1. If dlock=1: only data may be granted. Go to DGRANT if dREN|dWEN, else stay IDLE.
  2. Else if starve_cnt>=IMAX and any iREN: go to an instruction grant.
  3. Else if dREN|dWEN: go to DGNT.
  4. Else if any iREN: go to an instruction grant.
  - Instruction choice: if only one iREN is set, that core wins. If both are set, core ~last_i wins.
- Latency: a request seen in cycle N gives a RAM enable in cycle N+1. Minimum data-word latency is 2 cycles when RAM returns ACCESS on first touch.
- DGNT:
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are asserted); ramaddr=daddr; ramstore=dstore.
  - dload=ramload; dwait=(ramstate!=ACCESS).
  - On ACCESS, go to IDLE.
- IGNTk:
  - ramREN=1; ramaddr=iaddr[k]; iload=ramload; iwait[k]=(ramstate!=ACCESS); the other core's iwait stays 1.
  - On ACCESS, go to IDLE and set last_i=k.
- Requester drop: if the granted requester deasserts its request before ACCESS, return to IDLE next cycle with enables low that cycle. No wait is released and last_i is unchanged.
- ERROR: treated as not-complete, i.e. the wait stays high. Set ram_err, which clears only on RST.
- starve_cnt:
  - Increments, saturating at IMAX, in every cycle where some iREN=1 and the state is not IGNTx.
  - Clears on entry to any IGNTx.
  - Holds while no iREN is set.
- The data/instruction bubble of 1 IDLE cycle between grants is required. It gives requesters a cycle to drop REN after their wait falls.

Decomposition:
- ramstate_t and word_t come from cpu_types_pkg.
- New package items in cpu_types_pkg: the arb_state_t enum {IDLE, DGNT, IGNT0, IGNT1} and the IMAX default constant.
- Optional sub-module rr_pick2: the combinational 2-way round-robin picker (req[1:0], last → grant index, valid).

Test Plan:
- Data read alone: dREN=1, daddr=0x40, RAM returns ACCESS on its 2nd cycle with ramload=0xDEADBEEF.
  → ramREN=1, ramaddr=0x40 from cycle 1; dwait=0 and dload=0xDEADBEEF in cycle 2; IDLE in cycle 3.
- Data vs instruction conflict: dREN, iREN[0], iREN[1] all asserted together, RAM always ACCESS.
  → grant order is DGNT, IGNT0, IGNT1, each separated by one IDLE cycle.
- Burst lock: dlock=1 across two data words while iREN[1]=1 the whole time.
  → no IGNT1 until dlock falls; iwait[1] stays 1 throughout.
- Starvation, IMAX=8: dREN continuously re-asserted while iREN[0]=1, with RAM ACCESS after 3 cycles.
  → once starve_cnt reaches 8, the next IDLE grants IGNT0 ahead of the pending data request.
- Simultaneous dREN=dWEN=1 with dstore=0x12345678.
  → ramWEN=1, ramREN=0, ramstore=0x12345678.
- Error and reset: ramstate=ERROR in DGNT.
  → dwait stays 1 and ram_err=1. Assert RST for 1 cycle → IDLE with ram_err=0 next cycle.
